regfile_wb_ctrl: RTL and testbench
==================================

# regfile_wb_ctrl

Writeback controller for the 32-entry integer register file. It arbitrates between two writeback requesters: the ALU (single-cycle) and the LSU (variable-latency load return). The winner drives the register file's single write port through a registered stage. It also keeps a per-register pending scoreboard so the issue stage can detect RAW hazards on rs1/rs2 before reading the register file.

## Interface
- DW, 32, data width of a register
- AW, 5, register address width; NREG = 2**AW entries, x0 hard-wired zero

- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  synchronous reset, active-high
- alu_valid_i  in  1  ALU writeback request
- alu_ready_o  out  1  ALU request accepted this cycle
- alu_rd_addr_i  in  AW  ALU destination register
- alu_rd_data_i  in  DW  ALU result
- lsu_valid_i  in  1  LSU writeback request
- lsu_ready_o  out  1  LSU request accepted this cycle
- lsu_rd_addr_i  in  AW  LSU destination register
- lsu_rd_data_i  in  DW  load data
- iss_valid_i  in  1  instruction with a destination issued this cycle
- iss_rd_addr_i  in  AW  destination of the issued instruction
- rs1_addr_i, rs2_addr_i  in  AW each  source registers queried by issue
- rs1_busy_o, rs2_busy_o  out  1 each  source has an outstanding write
- rs1_fwd_valid_o, rs2_fwd_valid_o  out  1 each  forward data valid (WB_FWD_EN only, else tied 0)
- rs1_fwd_data_o, rs2_fwd_data_o  out  DW each  forward data (WB_FWD_EN only, else tied 0)
- rd_wren_o  out  1  register-file write enable (registered)
- rd_addr_o  out  AW  register-file write address (registered)
- rd_data_o  out  DW  register-file write data (registered)

## Operation
- **Handshake.** A transfer occurs on a requester when valid and ready are both high at a rising edge. Valid, addr and data must stay stable until the transfer. Ready is never high while its valid is low.
- **Arbitration.** Round-robin with a 1-bit last_grant register.
  - Only one requester valid: it gets ready.
  - Both valid: the one not in last_grant gets ready.
  - last_grant updates to the winner on every transfer.
- **Output stage.** The output stage updates every cycle:
  - On a transfer: rd_addr_o and rd_data_o load the winner's addr and data. rd_wren_o loads 1 if addr != 0, else 0. A write to x0 is accepted and discarded.
  - Without a transfer: rd_wren_o loads 0, and rd_addr_o and rd_data_o hold.
- **Scoreboard.** pending[NREG-1:0], with pending[0] constant 0.
  - Set: iss_valid_i with iss_rd_addr_i != 0 sets pending[iss_rd_addr_i].
  - Clear: at the edge that ends a cycle with rd_wren_o=1, pending[rd_addr_o] clears.
  - Same address set and cleared on the same edge: set wins.
  - Issuing a second writer to a register that is already pending (WAW) is illegal for the issue stage. The behaviour is undefined and is not checked.
- **Busy without WB_FWD_EN.** rsN_busy_o = pending[rsN_addr_i]. This is combinational from the registered state and the address inputs.
- **Reset.** While rst_i is high at an edge:
  - pending, rd_wren_o, rd_addr_o and rd_data_o are cleared to 0.
  - last_grant is set to LSU, so the ALU wins the first conflict.
  - Both ready outputs are forced low.
  - An in-flight write is dropped. Reset values are visible one edge after rst_i is sampled high.

## Timing
- Request to rd_wren_o: 1 cycle. The register file is written at the following edge, so data is readable 2 edges after the transfer.
- Requester throughput: 1 transfer per cycle total. Under sustained contention each requester gets 1 transfer every 2 cycles.
- Busy clear, without forwarding: busy deasserts the cycle after rd_wren_o was high. The register file then returns the new value.
- Ready and busy are combinational. No registered output depends combinationally on another output.

## Configuration
- Macro: WB_FWD_EN.
- **Defined:** while rd_wren_o=1 and rsN_addr_i == rd_addr_o (nonzero):
  - rsN_fwd_valid_o = 1 and rsN_fwd_data_o = rd_data_o.
  - rsN_busy_o is suppressed for that cycle, which saves one stall cycle.
  - Otherwise the fwd outputs are 0.
- **Undefined:** fwd outputs are tied 0, and busy follows pending only.

## Test plan
- **Reset:** assert rst_i for 2 cycles mid-traffic -> rd_wren_o=0, both ready=0 during reset, all busy=0 after, and an in-flight write is not performed.
- **Single requester:** issue x1; ALU writes x1=0xAAAA_AAAA -> rd_wren_o=1, rd_addr_o=1, rd_data_o=0xAAAA_AAAA one cycle later. rs1_busy_o for x1 is 1 until the cycle after the write.
- **Contention:** ALU and LSU both valid for 4 cycles (x2=0x5555_5555, x3=0x1234_5678, then new data each grant) -> grant order ALU, LSU, ALU, LSU. Each requester's data is written in order, and no transfer is lost.
- **x0 write:** LSU writes x0=0xDEAD_BEEF -> lsu_ready_o=1, rd_wren_o stays 0, rs2_busy_o for x0 stays 0.
- **Set/clear collision:** x6 write in flight (rd_wren_o=1, rd_addr_o=6) on the same cycle as iss_valid_i with rd=6 -> pending[6] remains 1 afterwards.
- **Forwarding (WB_FWD_EN):** rs1_addr_i=6 while rd_wren_o=1, rd_addr_o=6, rd_data_o=0x1200_1235 -> rs1_fwd_valid_o=1, rs1_fwd_data_o=0x1200_1235, rs1_busy_o=0. Without the macro: rs1_busy_o=1 and the fwd outputs are 0.

Source files
------------

// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl: round-robin ALU/LSU writeback arbiter with registered write port and pending scoreboard.
// Optional `WB_FWD_EN forwards the in-flight write to rs1/rs2 and suppresses their busy.
module regfile_wb_ctrl #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          alu_valid_i,
    output logic          alu_ready_o,
    input  logic [AW-1:0] alu_rd_addr_i,
    input  logic [DW-1:0] alu_rd_data_i,
    input  logic          lsu_valid_i,
    output logic          lsu_ready_o,
    input  logic [AW-1:0] lsu_rd_addr_i,
    input  logic [DW-1:0] lsu_rd_data_i,
    input  logic          iss_valid_i,
    input  logic [AW-1:0] iss_rd_addr_i,
    input  logic [AW-1:0] rs1_addr_i,
    input  logic [AW-1:0] rs2_addr_i,
    output logic          rs1_busy_o,
    output logic          rs2_busy_o,
    output logic          rs1_fwd_valid_o,
    output logic          rs2_fwd_valid_o,
    output logic [DW-1:0] rs1_fwd_data_o,
    output logic [DW-1:0] rs2_fwd_data_o,
    output logic          rd_wren_o,
    output logic [AW-1:0] rd_addr_o,
    output logic [DW-1:0] rd_data_o
);
    localparam int NREG = 2**AW;

    logic            last_grant;
    logic [NREG-1:0] pending, pending_nxt;
    logic            xfer;
    logic [AW-1:0]   win_addr;
    logic [DW-1:0]   win_data;

    // last_grant: 0 = ALU won last, 1 = LSU won last
    assign alu_ready_o = !rst_i && alu_valid_i && (!lsu_valid_i || last_grant);
    assign lsu_ready_o = !rst_i && lsu_valid_i && (!alu_valid_i || !last_grant);
    assign xfer        = alu_ready_o || lsu_ready_o;
    assign win_addr    = alu_ready_o ? alu_rd_addr_i : lsu_rd_addr_i;
    assign win_data    = alu_ready_o ? alu_rd_data_i : lsu_rd_data_i;

    // clear first so a same-edge set on the same register wins
    always_comb begin
        pending_nxt = pending;
        if (rd_wren_o) pending_nxt[rd_addr_o] = 1'b0;
        if (iss_valid_i && iss_rd_addr_i != '0) pending_nxt[iss_rd_addr_i] = 1'b1;
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending    <= '0;
            last_grant <= 1'b1;
            rd_wren_o  <= 1'b0;
            rd_addr_o  <= '0;
            rd_data_o  <= '0;
        end else begin
            pending    <= pending_nxt;
            last_grant <= xfer ? lsu_ready_o : last_grant;
            rd_wren_o  <= xfer && win_addr != '0;
            rd_addr_o  <= xfer ? win_addr : rd_addr_o;
            rd_data_o  <= xfer ? win_data : rd_data_o;
        end
    end

`ifdef WB_FWD_EN
    logic rs1_hit, rs2_hit;
    assign rs1_hit         = rd_wren_o && rs1_addr_i == rd_addr_o;
    assign rs2_hit         = rd_wren_o && rs2_addr_i == rd_addr_o;
    assign rs1_busy_o      = pending[rs1_addr_i] && !rs1_hit;
    assign rs2_busy_o      = pending[rs2_addr_i] && !rs2_hit;
    assign rs1_fwd_valid_o = rs1_hit;
    assign rs2_fwd_valid_o = rs2_hit;
    assign rs1_fwd_data_o  = rs1_hit ? rd_data_o : '0;
    assign rs2_fwd_data_o  = rs2_hit ? rd_data_o : '0;
`else
    assign rs1_busy_o      = pending[rs1_addr_i];
    assign rs2_busy_o      = pending[rs2_addr_i];
    assign rs1_fwd_valid_o = 1'b0;
    assign rs2_fwd_valid_o = 1'b0;
    assign rs1_fwd_data_o  = '0;
    assign rs2_fwd_data_o  = '0;
`endif
endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// tb_regfile_wb_ctrl: directed test-plan checks plus randomized traffic against a behavioural model.
module tb_regfile_wb_ctrl;
    logic        clk = 0, rst_i = 1;
    logic        alu_valid_i = 0, lsu_valid_i = 0, iss_valid_i = 0;
    logic        alu_ready_o, lsu_ready_o;
    logic [4:0]  alu_rd_addr_i = 0, lsu_rd_addr_i = 0, iss_rd_addr_i = 0, rs1_addr_i = 0, rs2_addr_i = 0;
    logic [31:0] alu_rd_data_i = 0, lsu_rd_data_i = 0;
    logic        rs1_busy_o, rs2_busy_o, rs1_fwd_valid_o, rs2_fwd_valid_o, rd_wren_o;
    logic [31:0] rs1_fwd_data_o, rs2_fwd_data_o, rd_data_o;
    logic [4:0]  rd_addr_o;

    int checks = 0, errors = 0;

    regfile_wb_ctrl dut (
        .clk_i(clk), .rst_i(rst_i),
        .alu_valid_i(alu_valid_i), .alu_ready_o(alu_ready_o),
        .alu_rd_addr_i(alu_rd_addr_i), .alu_rd_data_i(alu_rd_data_i),
        .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o),
        .lsu_rd_addr_i(lsu_rd_addr_i), .lsu_rd_data_i(lsu_rd_data_i),
        .iss_valid_i(iss_valid_i), .iss_rd_addr_i(iss_rd_addr_i),
        .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
        .rs1_busy_o(rs1_busy_o), .rs2_busy_o(rs2_busy_o),
        .rs1_fwd_valid_o(rs1_fwd_valid_o), .rs2_fwd_valid_o(rs2_fwd_valid_o),
        .rs1_fwd_data_o(rs1_fwd_data_o), .rs2_fwd_data_o(rs2_fwd_data_o),
        .rd_wren_o(rd_wren_o), .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // behavioural model: state as it stands after the next rising edge once updated at negedge
    bit          m_init = 0;
    bit [31:0]   m_pend = 0;
    bit          m_lsu_won_last = 1;
    bit          m_wren = 0;
    logic [4:0]  m_addr = 0;
    logic [31:0] m_data = 0;
    bit          alu_x = 0, lsu_x = 0;

    task automatic exp_src(input logic [4:0] rs, output bit busy, output bit fv, output logic [31:0] fd);
        bit hit;
        hit = 0;
`ifdef WB_FWD_EN
        hit = m_wren && rs == m_addr && rs != 0;
`endif
        busy = m_pend[rs] && !hit;
        fv = hit;
        fd = hit ? m_data : 32'h0;
    endtask

    always @(negedge clk) begin
        bit b1, b2, f1, f2;
        logic [31:0] d1, d2;
        bit both;
        both = alu_valid_i && lsu_valid_i;
        alu_x = !rst_i && alu_valid_i && (!both || m_lsu_won_last);
        lsu_x = !rst_i && lsu_valid_i && (!both || !m_lsu_won_last);
        if (m_init) begin
            exp_src(rs1_addr_i, b1, f1, d1);
            exp_src(rs2_addr_i, b2, f2, d2);
            chk("alu_ready", 32'(alu_ready_o), 32'(alu_x));
            chk("lsu_ready", 32'(lsu_ready_o), 32'(lsu_x));
            chk("rd_wren", 32'(rd_wren_o), 32'(m_wren));
            chk("rd_addr", 32'(rd_addr_o), 32'(m_addr));
            chk("rd_data", rd_data_o, m_data);
            chk("rs1_busy", 32'(rs1_busy_o), 32'(b1));
            chk("rs2_busy", 32'(rs2_busy_o), 32'(b2));
            chk("rs1_fwd_valid", 32'(rs1_fwd_valid_o), 32'(f1));
            chk("rs2_fwd_valid", 32'(rs2_fwd_valid_o), 32'(f2));
            chk("rs1_fwd_data", rs1_fwd_data_o, d1);
            chk("rs2_fwd_data", rs2_fwd_data_o, d2);
        end
        if (rst_i) begin
            m_init = 1;
            m_pend = 0;
            m_lsu_won_last = 1;
            m_wren = 0;
            m_addr = 0;
            m_data = 0;
        end else begin
            if (m_wren) m_pend[m_addr] = 0;
            if (iss_valid_i && iss_rd_addr_i != 0) m_pend[iss_rd_addr_i] = 1;
            m_wren = 0;
            if (alu_x || lsu_x) begin
                m_lsu_won_last = lsu_x;
                m_addr = alu_x ? alu_rd_addr_i : lsu_rd_addr_i;
                m_data = alu_x ? alu_rd_data_i : lsu_rd_data_i;
                m_wren = m_addr != 0;
            end
        end
    end

    logic [31:0] alu_d [2] = '{32'h5555_5555, 32'hA1A1_0002};
    logic [31:0] lsu_d [2] = '{32'h1234_5678, 32'hB2B2_0003};

    initial begin
        int ai, li, rst_cnt;
        repeat (2) step();
        rst_i = 0;
        chk("reset_wren", 32'(rd_wren_o), 32'h0);
        chk("reset_busy", 32'(rs1_busy_o), 32'h0);

        // contention right after reset: ALU first
        ai = 0; li = 0;
        alu_valid_i = 1; alu_rd_addr_i = 2; alu_rd_data_i = alu_d[0];
        lsu_valid_i = 1; lsu_rd_addr_i = 3; lsu_rd_data_i = lsu_d[0];
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("cont_alu_ready", 32'(alu_ready_o), 32'(k % 2 == 0));
            chk("cont_lsu_ready", 32'(lsu_ready_o), 32'(k % 2 == 1));
            step();
            chk("cont_rd_addr", 32'(rd_addr_o), (k % 2 == 0) ? 32'd2 : 32'd3);
            chk("cont_rd_data", rd_data_o, (k % 2 == 0) ? alu_d[k/2] : lsu_d[k/2]);
            chk("cont_rd_wren", 32'(rd_wren_o), 32'h1);
            if (k % 2 == 0) begin
                ai++;
                if (ai == 2) alu_valid_i = 0; else alu_rd_data_i = alu_d[ai];
            end else begin
                li++;
                if (li == 2) lsu_valid_i = 0; else lsu_rd_data_i = lsu_d[li];
            end
        end

        // single requester on x1
        iss_valid_i = 1; iss_rd_addr_i = 1;
        step();
        iss_valid_i = 0; rs1_addr_i = 1;
        #1 chk("x1_busy_issued", 32'(rs1_busy_o), 32'h1);
        alu_valid_i = 1; alu_rd_addr_i = 1; alu_rd_data_i = 32'hAAAA_AAAA;
        #1 chk("x1_alu_ready", 32'(alu_ready_o), 32'h1);
        step();
        alu_valid_i = 0;
        chk("x1_wren", 32'(rd_wren_o), 32'h1);
        chk("x1_addr", 32'(rd_addr_o), 32'h1);
        chk("x1_data", rd_data_o, 32'hAAAA_AAAA);
`ifdef WB_FWD_EN
        chk("x1_busy_wb", 32'(rs1_busy_o), 32'h0);
`else
        chk("x1_busy_wb", 32'(rs1_busy_o), 32'h1);
`endif
        step();
        chk("x1_wren_after", 32'(rd_wren_o), 32'h0);
        chk("x1_busy_after", 32'(rs1_busy_o), 32'h0);

        // write to x0 accepted and discarded
        lsu_valid_i = 1; lsu_rd_addr_i = 0; lsu_rd_data_i = 32'hDEAD_BEEF; rs2_addr_i = 0;
        #1 chk("x0_lsu_ready", 32'(lsu_ready_o), 32'h1);
        step();
        lsu_valid_i = 0;
        chk("x0_wren", 32'(rd_wren_o), 32'h0);
        chk("x0_busy", 32'(rs2_busy_o), 32'h0);

        // set/clear collision on x6 plus forwarding
        iss_valid_i = 1; iss_rd_addr_i = 6;
        step();
        iss_valid_i = 0;
        alu_valid_i = 1; alu_rd_addr_i = 6; alu_rd_data_i = 32'h1200_1235;
        step();
        alu_valid_i = 0;
        iss_valid_i = 1; iss_rd_addr_i = 6; rs1_addr_i = 6;
        #1;
        chk("x6_wren", 32'(rd_wren_o), 32'h1);
`ifdef WB_FWD_EN
        chk("x6_fwd_valid", 32'(rs1_fwd_valid_o), 32'h1);
        chk("x6_fwd_data", rs1_fwd_data_o, 32'h1200_1235);
        chk("x6_busy", 32'(rs1_busy_o), 32'h0);
`else
        chk("x6_fwd_valid", 32'(rs1_fwd_valid_o), 32'h0);
        chk("x6_fwd_data", rs1_fwd_data_o, 32'h0);
        chk("x6_busy", 32'(rs1_busy_o), 32'h1);
`endif
        step();
        iss_valid_i = 0;
        chk("x6_pending_kept", 32'(rs1_busy_o), 32'h1);
        alu_valid_i = 1; alu_rd_data_i = 32'h0000_0007;
        step();
        alu_valid_i = 0;
        step();
        chk("x6_cleared", 32'(rs1_busy_o), 32'h0);

        // reset mid-traffic with a write in flight
        iss_valid_i = 1; iss_rd_addr_i = 7;
        step();
        iss_valid_i = 0; rs1_addr_i = 7;
        alu_valid_i = 1; alu_rd_addr_i = 7; alu_rd_data_i = 32'h77;
        step();
        alu_valid_i = 0; rst_i = 1;
        lsu_valid_i = 1; lsu_rd_addr_i = 8; lsu_rd_data_i = 32'h88;
        #1 chk("rst_lsu_ready", 32'(lsu_ready_o), 32'h0);
        step();
        chk("rst_wren", 32'(rd_wren_o), 32'h0);
        chk("rst_busy", 32'(rs1_busy_o), 32'h0);
        chk("rst_lsu_ready2", 32'(lsu_ready_o), 32'h0);
        step();
        rst_i = 0;
        #1 chk("post_rst_lsu_ready", 32'(lsu_ready_o), 32'h1);
        chk("post_rst_data", rd_data_o, 32'h0);
        step();
        lsu_valid_i = 0;

        // randomized traffic
        rst_cnt = 0;
        for (int c = 0; c < 3000; c++) begin
            step();
            if (rst_cnt == 0 && $urandom_range(0, 299) == 0) rst_cnt = 2;
            rst_i = rst_cnt != 0;
            if (rst_cnt != 0) rst_cnt--;
            if (!alu_valid_i || alu_x) begin
                alu_valid_i = $urandom_range(0, 9) < 6;
                alu_rd_addr_i = 5'($urandom_range(0, 7));
                alu_rd_data_i = $urandom;
            end
            if (!lsu_valid_i || lsu_x) begin
                lsu_valid_i = $urandom_range(0, 9) < 6;
                lsu_rd_addr_i = 5'($urandom_range(0, 7));
                lsu_rd_data_i = $urandom;
            end
            iss_rd_addr_i = 5'($urandom_range(0, 7));
            iss_valid_i = $urandom_range(0, 2) == 0 && !m_pend[iss_rd_addr_i];
            rs1_addr_i = $urandom_range(0, 3) == 0 ? m_addr : 5'($urandom_range(0, 7));
            rs2_addr_i = $urandom_range(0, 3) == 0 ? m_addr : 5'($urandom_range(0, 7));
        end
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
